// File: rtl/teller_dispatch.sv
// rtl/teller_dispatch.sv - round-robin teller call dispatcher with queue dequeue handshake and 7-seg hall display
// Optional ack timeout abort is enabled by defining DISPATCH_TIMEOUT_EN.
module teller_dispatch #(
  parameter int N_TELLERS   = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clock_i,
  input  logic                 clear_n_i,
  input  logic [N_TELLERS-1:0] next_req_i,
  input  logic                 q_empty_i,
  input  logic                 deq_ack_i,
  output logic                 deq_req_o,
  output logic                 call_valid_o,
  output logic [6:0]           call_ticket_o,
  output logic [2:0]           call_teller_o,
  output logic [N_TELLERS-1:0] pending_o,
  output logic                 timeout_err_o,
  output logic [6:0]           led_tens_o,
  output logic [6:0]           led_ones_o,
  output logic [6:0]           led_teller_o
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_WAIT_Q, S_DEQ, S_ANNOUNCE} state_t;

  state_t               state_q, state_d;
  logic [N_TELLERS-1:0] req_q, pending_q, pending_d, rise, clr;
  logic [2:0]           sel_q, sel_d, rr_q, rr_d, arb_idx, teller_q, teller_d;
  logic [6:0]           ticket_q, ticket_d, next_ticket_q, next_ticket_d;
  logic                 valid_q, valid_d;
  logic [7:0]           pend_ext, clr_ext;

  // Scan from the highest offset down so the nearest pending teller at or after rr_q wins.
  always_comb begin
    logic [3:0] pos;
    pos      = '0;
    pend_ext = 8'(pending_q);
    arb_idx  = rr_q;
    for (int k = N_TELLERS - 1; k >= 0; k--) begin
      pos = {1'b0, rr_q} + 4'(k);
      if (pos >= 4'(N_TELLERS)) pos = pos - 4'(N_TELLERS);
      if (pend_ext[pos[2:0]]) arb_idx = pos[2:0];
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] timer_q;
  logic          err_q;
  logic          timeout_fire;

  assign timeout_fire  = (state_q == S_DEQ) && !deq_ack_i && (timer_q == TW'(ACK_TIMEOUT - 1));
  assign timeout_err_o = err_q;

  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= (state_q == S_DEQ) ? timer_q + 1'b1 : '0;
      err_q   <= err_q | timeout_fire;
    end
  end
`else
  assign timeout_err_o = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rr_d          = rr_q;
    ticket_d      = ticket_q;
    teller_d      = teller_q;
    next_ticket_d = next_ticket_q;
    valid_d       = 1'b0;
    clr_ext       = '0;
    deq_req_o     = 1'b0;
    rise          = next_req_i & ~req_q;
    case (state_q)
      S_IDLE:   if (|pending_q) state_d = S_ARB;
      S_ARB: begin
        sel_d   = arb_idx;
        state_d = q_empty_i ? S_WAIT_Q : S_DEQ;
      end
      S_WAIT_Q: if (!q_empty_i) state_d = S_DEQ;
      S_DEQ: begin
        deq_req_o = 1'b1;
        if (deq_ack_i) state_d = S_ANNOUNCE;
`ifdef DISPATCH_TIMEOUT_EN
        else if (timeout_fire) state_d = S_IDLE;
`endif
      end
      S_ANNOUNCE: begin
        ticket_d      = next_ticket_q;
        teller_d      = sel_q + 3'd1;
        valid_d       = 1'b1;
        clr_ext       = 8'd1 << sel_q;
        rr_d          = (sel_q == 3'(N_TELLERS - 1)) ? 3'd0 : sel_q + 3'd1;
        next_ticket_d = (next_ticket_q == 7'd99) ? 7'd1 : next_ticket_q + 7'd1;
        state_d       = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    clr       = clr_ext[N_TELLERS-1:0];
    // A fresh press on the teller being served survives the clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      state_q       <= S_IDLE;
      req_q         <= '0;
      pending_q     <= '0;
      sel_q         <= '0;
      rr_q          <= '0;
      ticket_q      <= '0;
      teller_q      <= '0;
      next_ticket_q <= 7'd1;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= next_req_i;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      rr_q          <= rr_d;
      ticket_q      <= ticket_d;
      teller_q      <= teller_d;
      next_ticket_q <= next_ticket_d;
      valid_q       <= valid_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h7E;
      4'd1:    seg7 = 7'h30;
      4'd2:    seg7 = 7'h6D;
      4'd3:    seg7 = 7'h79;
      4'd4:    seg7 = 7'h33;
      4'd5:    seg7 = 7'h5B;
      4'd6:    seg7 = 7'h5F;
      4'd7:    seg7 = 7'h70;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h7B;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign call_valid_o  = valid_q;
  assign call_ticket_o = ticket_q;
  assign call_teller_o = teller_q;
  assign pending_o     = pending_q;
  assign led_tens_o    = seg7(4'(ticket_q / 7'd10));
  assign led_ones_o    = seg7(4'(ticket_q % 7'd10));
  assign led_teller_o  = seg7({1'b0, teller_q});

endmodule

// File: tb/tb_teller_dispatch.sv
// tb/tb_teller_dispatch.sv - scoreboard bench for teller_dispatch with randomized presses, queue stalls and ack delays
module tb_teller_dispatch;
  localparam int N  = 3;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic [N-1:0] next_req = '0;
  logic         q_empty;
  logic         deq_ack = 1'b0;
  logic         deq_req, call_valid, timeout_err;
  logic [6:0]   call_ticket, led_tens, led_ones, led_teller;
  logic [2:0]   call_teller;
  logic [N-1:0] pending;

  teller_dispatch #(.N_TELLERS(N), .ACK_TIMEOUT(TO)) dut (
    .clock_i(clk), .clear_n_i(clear_n), .next_req_i(next_req), .q_empty_i(q_empty),
    .deq_ack_i(deq_ack), .deq_req_o(deq_req), .call_valid_o(call_valid),
    .call_ticket_o(call_ticket), .call_teller_o(call_teller), .pending_o(pending),
    .timeout_err_o(timeout_err), .led_tens_o(led_tens), .led_ones_o(led_ones),
    .led_teller_o(led_teller)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           ticket;
    int           teller;
    logic [N-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail = 0;
  int   issued = 0;
  int   rr = 0;
  bit   ack_en = 1'b0;
  int   ack_dmax = 0;
  int   qe_mode = 0;
  bit   qe_rand = 1'b0;
  bit   saw99 = 1'b0;
  bit   saw_wrap = 1'b0;

  assign q_empty = (qe_mode == 1) || (qe_mode == 2 && qe_rand);

  function automatic int seg(input int d);
    case (d)
      0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
      4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
      8: return 7'h7F;  9: return 7'h7B;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: tellers are served in cyclic order starting at the pointer; tickets run 1..99 repeating.
  task automatic model_batch(input logic [N-1:0] mask);
    logic [N-1:0] rem;
    int           idx;
    exp_t         e;
    rem = mask;
    while (rem != '0) begin
      idx = -1;
      for (int k = 0; k < N; k++)
        if (idx < 0 && rem[(rr + k) % N]) idx = (rr + k) % N;
      rem[idx] = 1'b0;
      e.ticket = (issued % 99) + 1;
      e.teller = idx + 1;
      e.pend   = rem;
      exp_q.push_back(e);
      issued++;
      rr = (idx + 1) % N;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL call_timeout: %0d calls outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic press_batch(input logic [N-1:0] mask, input int hold);
    model_batch(mask);
    @(negedge clk);
    next_req = mask;
    repeat (hold) @(negedge clk);
    next_req = '0;
    wait_done();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n  = 1'b0;
    next_req = '0;
    issued   = 0;
    rr       = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
  endtask

  always @(negedge clk) qe_rand <= ($urandom_range(0, 3) == 0);

  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (ack_en && clear_n && deq_req && !deq_ack) begin
        d = $urandom_range(0, ack_dmax);
        repeat (d) @(negedge clk);
        deq_ack = 1'b1;
      end else begin
        deq_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (clear_n && call_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_call: got ticket %0d teller %0d, required no call", call_ticket, call_teller);
      end else begin
        e_mon = exp_q.pop_front();
        check("call_ticket", int'(call_ticket), e_mon.ticket);
        check("call_teller", int'(call_teller), e_mon.teller);
        check("pending_after_call", int'(pending), int'(e_mon.pend));
        check("led_tens", int'(led_tens), seg(e_mon.ticket / 10));
        check("led_ones", int'(led_ones), seg(e_mon.ticket % 10));
        check("led_teller", int'(led_teller), seg(e_mon.teller));
        if (e_mon.ticket == 99) saw99 = 1'b1;
        if (e_mon.ticket == 1 && saw99) saw_wrap = 1'b1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [N-1:0] m;
    do_reset();
    #1;
    check("rst_deq_req", int'(deq_req), 0);
    check("rst_call_valid", int'(call_valid), 0);
    check("rst_call_ticket", int'(call_ticket), 0);
    check("rst_call_teller", int'(call_teller), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_led_tens", int'(led_tens), seg(0));
    check("rst_led_ones", int'(led_ones), seg(0));
    check("rst_led_teller", int'(led_teller), seg(0));

    // First call with immediate ack: call_valid four edges after the press edge.
    ack_en = 1'b1;
    ack_dmax = 0;
    model_batch(3'b001);
    @(negedge clk);
    next_req = 3'b001;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!call_valid && n < 20);
    check("first_call_latency", n - 1, 4);
    @(negedge clk);
    next_req = '0;
    wait_done();

    do_reset();
    press_batch(3'b111, 1);

    // Queue empty: dispatcher must park without requesting.
    qe_mode = 1;
    model_batch(3'b010);
    @(negedge clk);
    next_req = 3'b010;
    @(negedge clk);
    next_req = '0;
    repeat (8) @(negedge clk);
    check("waitq_deq_req", int'(deq_req), 0);
    check("waitq_pending", int'(pending), 3'b010);
    qe_mode = 0;
    @(negedge clk);
    check("waitq_release_deq_req", int'(deq_req), 1);
    wait_done();

    ack_dmax = 3;
    qe_mode = 2;
    while (issued < 104) begin
      m = 3'($urandom_range(1, (1 << N) - 1));
      press_batch(m, $urandom_range(1, 5));
    end
    qe_mode = 0;
    check("ticket_reached_99", int'(saw99), 1);
    check("ticket_wrapped_to_1", int'(saw_wrap), 1);

    // Reset while a dequeue request is outstanding.
    ack_en = 1'b0;
    @(negedge clk);
    next_req = 3'b100;
    @(negedge clk);
    next_req = '0;
    n = 0;
    while (!deq_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_deq_req_seen", int'(deq_req), 1);
    clear_n = 1'b0;
    #1;
    check("midrst_deq_req", int'(deq_req), 0);
    check("midrst_pending", int'(pending), 0);
    check("midrst_call_ticket", int'(call_ticket), 0);
    issued = 0;
    rr = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
    ack_en = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_pending", int'(pending), 0);

`ifdef DISPATCH_TIMEOUT_EN
    ack_en = 1'b0;
    @(negedge clk);
    next_req = 3'b010;
    @(negedge clk);
    next_req = '0;
    n = 0;
    while (!deq_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (deq_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", n, TO);
    check("timeout_deq_req", int'(deq_req), 0);
    check("timeout_err_set", int'(timeout_err), 1);
    check("timeout_pending_kept", int'(pending[1]), 1);
    model_batch(3'b010);
    ack_en = 1'b1;
    ack_dmax = 0;
    wait_done();
    check("timeout_err_sticky", int'(timeout_err), 1);
`else
    check("timeout_err_tied", int'(timeout_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
